// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the APB master arbiter and its bench.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Width of the ACCESS-phase timeout counter; never narrower than one bit.
    function automatic int tmo_cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: first request at or after ptr, wrapping to slot 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int PW = $clog2(NUM_REQ);

    // Search ptr..NUM_REQ-1 first, then wrap around to 0..ptr-1.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                grant[i] = 1'b1;
                idx      = PW'(i);
                any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                grant[i] = 1'b1;
                idx      = PW'(i);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters with round-robin
// arbitration, SETUP/ACCESS sequencing and an optional ACCESS-phase timeout.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0]    req_wdata_i,
    input  logic [NUM_REQ-1:0]                   req_we_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [APB_DATA_WIDTH-1:0]            rsp_rdata_o,
    output logic                                 rsp_err_o,
    output logic [APB_ADDR_WIDTH-1:0]            paddr,
    output logic [APB_DATA_WIDTH-1:0]            pwdata,
    output logic                                 pwrite,
    output logic                                 psel,
    output logic                                 penable,
    input  logic [APB_DATA_WIDTH-1:0]            prdata,
    input  logic                                 pready,
    input  logic                                 pslverr
);

    localparam int AW = APB_ADDR_WIDTH;
    localparam int DW = APB_DATA_WIDTH;
    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = tmo_cnt_width(TIMEOUT);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_REQ = PW'(NUM_REQ - 1);

    apb_state_e         state, state_d;
    logic [PW-1:0]      rr_ptr, rr_ptr_d;
    logic [PW-1:0]      gidx, gidx_d;
    logic [CW-1:0]      tmo_cnt, tmo_cnt_d;
    logic [NUM_REQ-1:0] req_ready_d, rsp_valid_d;
    logic [DW-1:0]      rsp_rdata_d;
    logic               rsp_err_d;
    logic [AW-1:0]      paddr_d;
    logic [DW-1:0]      pwdata_d;
    logic               pwrite_d, psel_d, penable_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [PW-1:0]      arb_idx;
    logic               arb_any;
    logic [AW-1:0]      sel_addr;
    logic [DW-1:0]      sel_wdata;
    logic               sel_we;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req  (req_valid_i),
        .ptr  (rr_ptr),
        .grant(arb_grant),
        .idx  (arb_idx),
        .any  (arb_any)
    );

    // Pick the granted slot's address, write data and direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_addr  = req_addr_i[i*AW +: AW];
                sel_wdata = req_wdata_i[i*DW +: DW];
                sel_we    = req_we_i[i];
            end
        end
    end

    // Next-state and next registered-output values; everything holds unless changed.
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gidx_d      = gidx;
        tmo_cnt_d   = tmo_cnt;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        paddr_d     = paddr;
        pwdata_d    = pwdata;
        pwrite_d    = pwrite;
        psel_d      = psel;
        penable_d   = penable;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_grant;
                    paddr_d     = sel_addr;
                    pwdata_d    = sel_wdata;
                    pwrite_d    = sel_we;
                    gidx_d      = arb_idx;
                    rr_ptr_d    = (arb_idx == LAST_REQ) ? '0 : arb_idx + 1'b1;
                    psel_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                tmo_cnt_d = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    rsp_valid_d[gidx] = 1'b1;
                    rsp_err_d         = pslverr;
                    if (!pwrite) begin
                        rsp_rdata_d = prdata;
                    end
                    state_d = IDLE;
                end else if ((TIMEOUT != 0) && (tmo_cnt == TMO_LAST)) begin
                    psel_d            = 1'b0;
                    penable_d         = 1'b0;
                    rsp_valid_d[gidx] = 1'b1;
                    rsp_err_d         = 1'b1;
                    rsp_rdata_d       = '0;
                    state_d           = IDLE;
                end else if (tmo_cnt != '1) begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered outputs, arbitration pointer and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            gidx        <= '0;
            tmo_cnt     <= '0;
            req_ready_o <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
        end else begin
            rr_ptr      <= rr_ptr_d;
            gidx        <= gidx_d;
            tmo_cnt     <= tmo_cnt_d;
            req_ready_o <= req_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            pwrite      <= pwrite_d;
            psel        <= psel_d;
            penable     <= penable_d;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a response scoreboard queue.
module tb_apb_master_arbiter;
    import apb_arb_pkg::*;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    logic [N*AW-1:0] req_addr_i;
    logic [N*DW-1:0] req_wdata_i;
    logic [N-1:0]    req_we_i;
    logic [N-1:0]    rsp_valid_o;
    logic [DW-1:0]   rsp_rdata_o;
    logic            rsp_err_o;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic            pwrite;
    logic            psel;
    logic            penable;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        expq[$];
    int          grantq[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_rdata = '0;

    apb_master_arbiter #(
        .NUM_REQ(N),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .req_we_i   (req_we_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o  (rsp_err_o),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pwrite     (pwrite),
        .psel       (psel),
        .penable    (penable),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Raise one request and wait (bounded) for its accept strobe, then withdraw it.
    task automatic applyStimulus(input string tag, input int idx, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic we);
        int n;
        req_addr_i[idx*AW +: AW]  = addr;
        req_wdata_i[idx*DW +: DW] = wdata;
        req_we_i[idx]             = we;
        req_valid_i[idx]          = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready_o == '0 && n < 20);
        checkOutput({tag, "_ready"}, 32'(req_ready_o), 32'(1) << idx);
        req_valid_i[idx] = 1'b0;
    endtask

    // Compare the current response strobe against the oldest scoreboard entry.
    task automatic expectResponse(input string tag);
        rsp_t e;
        if (expq.size() == 0) begin
            tests++;
            fails++;
            $error("[TB] FAIL %s_sb_empty: observed=%h expected=none", tag, rsp_valid_o);
        end else begin
            e = expq.pop_front();
            checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid_o), 32'(1) << e.idx);
            checkOutput({tag, "_rdata"}, rsp_rdata_o, e.rdata);
            checkOutput({tag, "_err"}, 32'(rsp_err_o), 32'(e.err));
        end
    endtask

    // One complete transfer: grant, SETUP, waits/timeout in ACCESS, response.
    task automatic doTransfer(input string tag, input int idx, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic we, input int waits,
                              input logic [31:0] prd, input logic slverr, input logic tmo);
        rsp_t e;
        applyStimulus(tag, idx, addr, wdata, we);
        checkOutput({tag, "_setup_psel"}, 32'(psel), 32'd1);
        checkOutput({tag, "_setup_penable"}, 32'(penable), 32'd0);
        checkOutput({tag, "_paddr"}, paddr, addr);
        checkOutput({tag, "_pwrite"}, 32'(pwrite), 32'(we));
        if (we) checkOutput({tag, "_pwdata"}, pwdata, wdata);
        e.idx = idx;
        e.err = tmo ? 1'b1 : slverr;
        if (tmo) model_rdata = '0;
        else if (!we) model_rdata = prd;
        e.rdata = model_rdata;
        expq.push_back(e);
        @(negedge clk);
        for (int w = 0; w < waits; w++) begin
            checkOutput({tag, "_wait_access"}, 32'({psel, penable}), 32'b11);
            checkOutput({tag, "_wait_paddr"}, paddr, addr);
            if (we) checkOutput({tag, "_wait_pwdata"}, pwdata, wdata);
            @(negedge clk);
        end
        if (!tmo) begin
            checkOutput({tag, "_access"}, 32'({psel, penable}), 32'b11);
            pready  = 1'b1;
            prdata  = prd;
            pslverr = slverr;
            @(negedge clk);
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = '0;
        end
        checkOutput({tag, "_bus_idle"}, 32'({psel, penable}), 32'b00);
        expectResponse(tag);
        @(negedge clk);
        checkOutput({tag, "_rsp_pulse"}, 32'(rsp_valid_o), 32'd0);
    endtask

    initial begin
        int cnt[N];
        int grants;
        int rsps;
        int cyc;
        logic [31:0] expv;

        rst         = 1'b1;
        req_valid_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_we_i    = '0;
        prdata      = '0;
        pready      = 1'b0;
        pslverr     = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_psel", 32'({psel, penable, pwrite}), 32'd0);
        checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_paddr", paddr, 32'd0);
        checkOutput("rst_pwdata", pwdata, 32'd0);
        checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
        checkOutput("rst_err", 32'(rsp_err_o), 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single read");
        doTransfer("t1", 0, 32'h1A10_1000, 32'h0, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);

        $display("[TB] write with 3 wait states");
        doTransfer("t2", 2, 32'h1A10_1008, 32'h0000_00A5, 1'b1, 3, 32'h1111_1111, 1'b0, 1'b0);

        $display("[TB] slave error on read");
        doTransfer("t4", 1, 32'h1A10_2000, 32'h0, 1'b0, 0, 32'h1234_5678, 1'b1, 1'b0);

        $display("[TB] timeout then normal write");
        doTransfer("t5", 3, 32'h1A10_3000, 32'h0, 1'b0, TMO, 32'h0, 1'b0, 1'b1);
        doTransfer("t5n", 0, 32'h1A10_3004, 32'hCAFE_0001, 1'b1, 1, 32'h7777_7777, 1'b0, 1'b0);

        $display("[TB] reset during ACCESS");
        applyStimulus("t6", 2, 32'h1A10_4000, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("t6_in_access", 32'({psel, penable}), 32'b11);
        rst    = 1'b1;
        pready = 1'b1;
        @(negedge clk);
        checkOutput("t6_bus_dropped", 32'({psel, penable}), 32'b00);
        checkOutput("t6_no_rsp", 32'(rsp_valid_o), 32'd0);
        checkOutput("t6_rdata_clr", rsp_rdata_o, 32'd0);
        rst         = 1'b0;
        model_rdata = '0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t6_no_rsp_after", 32'(rsp_valid_o), 32'd0);
        end
        checkOutput("t6_state", 32'(dut.state), 32'(IDLE));
        pready = 1'b0;

        $display("[TB] round robin with all requesters held");
        for (int i = 0; i < N; i++) begin
            cnt[i]                  = 0;
            req_addr_i[i*AW +: AW]  = 32'h4000_0000 + 32'(i * 16);
            req_we_i[i]             = 1'b0;
        end
        prdata      = 32'h5A5A_A5A5;
        pready      = 1'b1;
        model_rdata = 32'h5A5A_A5A5;
        for (int k = 0; k < 8; k++) begin
            rsp_t e;
            grantq.push_back(k % N);
            e.idx   = k % N;
            e.rdata = model_rdata;
            e.err   = 1'b0;
            expq.push_back(e);
        end
        grants      = 0;
        rsps        = 0;
        cyc         = 0;
        req_valid_i = '1;
        while (rsps < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (req_ready_o != '0) begin
                if (grantq.size() != 0) begin
                    int g;
                    g    = grantq.pop_front();
                    expv = 32'(1) << g;
                    checkOutput("t3_paddr", paddr, 32'h4000_0000 + 32'(g * 16));
                end else begin
                    expv = 32'd0;
                end
                checkOutput("t3_grant", 32'(req_ready_o), expv);
                for (int i = 0; i < N; i++) if (req_ready_o[i]) cnt[i]++;
                grants++;
                if (grants == 8) req_valid_i = '0;
            end
            if (rsp_valid_o != '0) begin
                expectResponse("t3");
                rsps++;
            end
        end
        pready = 1'b0;
        checkOutput("t3_rsp_count", 32'(rsps), 32'd8);
        for (int i = 0; i < N; i++) checkOutput("t3_grants_per_req", 32'(cnt[i]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
